// File: rtl/disp_ctrl_scheduler.sv
// Display-select code scheduler: debounced manual stepping, timed auto-cycling and hold.
// Drives the 4-bit disp_ctrl field selects of the seven-segment display multiplexer.

module disp_ctrl_debounce #(
   parameter int DEB_CYCLES = 1000000,
   parameter int DEB_W      = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             press_q, press_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
         // the final qualifying cycle accepts the level instead of counting on
         if (cnt_q == DEB_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = deb_d & ~deb_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// state  | meaning
// MANUAL | buttons step the field selects, dwell counter held at 0
// AUTO   | dwell counter runs, code advances on expiry; presses still step
// HOLD   | code frozen, dwell paused, press pulses dropped
module disp_ctrl_scheduler #(
   parameter int DEB_CYCLES   = 1000000,
   parameter int DEB_W        = 20,
   parameter int DWELL_CYCLES = 200000000,
   parameter int DWELL_W      = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_hi,
   input  logic       btn_lo,
   input  logic       auto_en,
   input  logic       hold,
   output logic [3:0] disp_ctrl,
   output logic [1:0] mode,
   output logic       sel_changed
);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_AUTO   = 2'b01,
      ST_HOLD   = 2'b10
   } state_t;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   state_t             state_q, state_d;
   logic [3:0]         disp_q, disp_d;
   logic               sel_q, sel_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   logic press_hi, press_lo;
   logic press_any;
   logic [3:0] disp_step;

   disp_ctrl_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
   ) u_deb_hi (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_hi),
      .press   (press_hi)
   );

   disp_ctrl_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
   ) u_deb_lo (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_lo),
      .press   (press_lo)
   );

   always_comb begin
      if (hold) begin
         state_d = ST_HOLD;
      end else if (auto_en) begin
         state_d = ST_AUTO;
      end else begin
         state_d = ST_MANUAL;
      end
   end

   // Actions follow the state being entered, so hold freezes on the cycle it is seen.
   always_comb begin
      disp_d    = disp_q;
      dwell_d   = dwell_q;
      press_any = press_hi | press_lo;
      disp_step = {disp_q[3:2] + {1'b0, press_hi}, disp_q[1:0] + {1'b0, press_lo}};

      case (state_d)
         ST_MANUAL: begin
            dwell_d = '0;
            if (press_any) begin
               disp_d = disp_step;
            end
         end
         ST_AUTO: begin
            if (press_any) begin
               disp_d  = disp_step;
               dwell_d = '0;
            end else if (state_q == ST_MANUAL) begin
               dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
               disp_d  = disp_q + 4'd1;
               dwell_d = '0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: begin
         end
      endcase

      sel_d = (disp_d != disp_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_MANUAL;
         disp_q  <= 4'd0;
         sel_q   <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         sel_q   <= sel_d;
         dwell_q <= dwell_d;
      end
   end

   assign disp_ctrl   = disp_q;
   assign mode        = state_q;
   assign sel_changed = sel_q;

endmodule
